neuron_learn_layer_seq: RTL and testbench

- Generic M-neuron learning layer, replacing the fixed-count, hand-unrolled layers.
- Generate-instantiates M neuron_learn cores that share one input vector.
- Adds a start/ready/out_valid handshake with a sequencing FSM.
- Replaces the combinational expected_in average tree with a time-multiplexed column accumulator that processes L neurons per cycle, then divides by M.
- Sits between adjacent layers; the network controller drives it.

---
 rtl/neuron_layer_pkg.sv | 22 ++
 rtl/layer_expected_in_accumulator.sv | 71 +++++++
 rtl/neuron_learn.sv | 55 +++++
 rtl/neuron_learn_layer_seq.sv | 133 +++++++++++++
 tb/tb_neuron_learn_layer_seq.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/neuron_layer_pkg.sv
// Shared types for the sequenced learning layer: fixed-point lane types, FSM states
// and the width of the expected_in column accumulator.
package neuron_layer_pkg;

    typedef logic [7:0]         zero2one_t;
    typedef logic signed [15:0] frac_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACC,
        DIV,
        DONE
    } layer_state_t;

    // A column sum of m unsigned zero2one_t values can never exceed this width.
    function automatic int acc_width(input int m);
        return $bits(zero2one_t) + $clog2(m + 1);
    endfunction

endpackage

// File: rtl/layer_expected_in_accumulator.sv
// Time-multiplexed column accumulator: sums L neurons per step, then divides by M.
// ceil(M/L) step cycles plus one divide cycle; driven entirely by the layer FSM.
module layer_expected_in_accumulator
    import neuron_layer_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 46,
    parameter int L = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      step,
    input  logic                      divide,
    input  zero2one_t [M-1:0][N-1:0]  unavg,
    output logic                      last_group,
    output zero2one_t [N-1:0]         avg
);

    localparam int G  = (M + L - 1) / L;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int AW = acc_width(M);

    typedef logic [AW-1:0] acc_t;

    zero2one_t [N-1:0] lanes [G][L];
    logic [GW-1:0]     g;
    acc_t [N-1:0]      acc;
    acc_t [N-1:0]      col_sum;

    // Phantom lanes past the last neuron are tied to zero so the final group needs no mask logic.
    for (genvar gi = 0; gi < G; gi++) begin : g_group
        for (genvar k = 0; k < L; k++) begin : g_lane
            if (gi * L + k < M) begin : g_real
                assign lanes[gi][k] = unavg[gi * L + k];
            end else begin : g_phantom
                assign lanes[gi][k] = '0;
            end
        end
    end

    always_comb begin
        col_sum = acc;
        for (int j = 0; j < N; j++)
            for (int k = 0; k < L; k++)
                col_sum[j] = col_sum[j] + acc_t'(lanes[g][k][j]);
    end

    assign last_group = (g == GW'(G - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            g   <= '0;
            acc <= '0;
            avg <= '0;
        end else begin
            if (clear) begin
                g   <= '0;
                acc <= '0;
            end else if (step) begin
                acc <= col_sum;
                g   <= last_group ? '0 : g + GW'(1);
            end
            if (divide) begin
                for (int j = 0; j < N; j++)
                    avg[j] <= zero2one_t'(acc[j] / acc_t'(M));
            end
        end
    end

endmodule

// File: rtl/neuron_learn.sv
// Single learning neuron: clipped-input activation, per-input expected_in, weight nudge.
// One cycle from valid to stable out/expected_in; weights are deliberately not reset.
module neuron_learn
    import neuron_layer_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid,
    input  logic                  learn,
    input  zero2one_t [N-1:0]     in,
    input  zero2one_t             expected_out,
    output zero2one_t             out,
    output zero2one_t [N-1:0]     expected_in,
    output frac_t     [N-1:0]     weights,
    output frac_t                 activation_max,
    output frac_t                 activation_min
);

    zero2one_t [N-1:0] clip;
    zero2one_t         peak;

    // Each input is clipped to the target; the activation is the strongest clipped input.
    always_comb begin
        clip = '0;
        peak = '0;
        for (int j = 0; j < N; j++) begin
            clip[j] = (in[j] < expected_out) ? in[j] : expected_out;
            if (clip[j] > peak) peak = clip[j];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out            <= '0;
            expected_in    <= '0;
            activation_max <= {1'b1, 15'b0};
            activation_min <= {1'b0, {15{1'b1}}};
        end else if (valid) begin
            out         <= peak;
            expected_in <= clip;
            if (frac_t'(peak) > activation_max) activation_max <= frac_t'(peak);
            if (frac_t'(peak) < activation_min) activation_min <= frac_t'(peak);
        end
    end

    always_ff @(posedge clock) begin
        if (valid && learn) begin
            for (int j = 0; j < N; j++)
                weights[j] <= weights[j] + frac_t'(in[j]) - frac_t'(expected_out);
        end
    end

endmodule

// File: rtl/neuron_learn_layer_seq.sv
// M-neuron learning layer with start/ready handshake; one request in flight at a time.
// out_valid 2+NEURON_LAT cycles after accept (inference) or 3+NEURON_LAT+ceil(M/L) (learn).
module neuron_learn_layer_seq
    import neuron_layer_pkg::*;
#(
    parameter int N          = 16,
    parameter int M          = 46,
    parameter int L          = 8,
    parameter int NEURON_LAT = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      learn,
    input  zero2one_t [N-1:0]         in,
    input  zero2one_t [M-1:0]         expected_out,
    output logic                      ready,
    output zero2one_t [M-1:0]         out,
    output logic                      out_valid,
    output zero2one_t [N-1:0]         expected_in,
    output logic                      expected_in_valid,
    output frac_t     [M-1:0][N-1:0]  weights,
    output frac_t     [M-1:0]         activation_max,
    output frac_t     [M-1:0]         activation_min
);

    if (L < 1 || L > M) begin : g_bad_l
        $error("neuron_learn_layer_seq: L must lie in 1..M");
    end
    if (NEURON_LAT < 1) begin : g_bad_lat
        $error("neuron_learn_layer_seq: NEURON_LAT must be at least 1");
    end

    localparam int WCW = (NEURON_LAT > 1) ? $clog2(NEURON_LAT) : 1;

    layer_state_t             state, state_nxt;
    zero2one_t [N-1:0]        in_q;
    zero2one_t [M-1:0]        exp_q;
    logic                     learn_q;
    logic [WCW-1:0]           wait_cnt;
    logic                     core_valid, acc_clear, acc_step, acc_div, capture_out;
    logic                     last_group;
    zero2one_t [M-1:0]        core_out;
    zero2one_t [M-1:0][N-1:0] core_ei;

    assign ready             = (state == IDLE) && !reset;
    assign out_valid         = (state == DONE) && !reset;
    assign expected_in_valid = out_valid && learn_q;

    always_comb begin
        state_nxt   = state;
        core_valid  = 1'b0;
        acc_clear   = 1'b0;
        acc_step    = 1'b0;
        acc_div     = 1'b0;
        capture_out = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = ISSUE;
            ISSUE: begin
                core_valid = 1'b1;
                acc_clear  = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    capture_out = 1'b1;
                    state_nxt   = learn_q ? ACC : DONE;
                end
            end
            ACC: begin
                acc_step = 1'b1;
                if (last_group) state_nxt = DIV;
            end
            DIV: begin
                acc_div   = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            in_q     <= '0;
            exp_q    <= '0;
            learn_q  <= 1'b0;
            wait_cnt <= '0;
            out      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                in_q    <= in;
                exp_q   <= expected_out;
                learn_q <= learn;
            end
            if (state == ISSUE)
                wait_cnt <= WCW'(NEURON_LAT - 1);
            else if (state == WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - WCW'(1);
            if (capture_out) out <= core_out;
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_core
        neuron_learn #(.N(N)) u_core (
            .clock          (clock),
            .reset          (reset),
            .valid          (core_valid),
            .learn          (core_valid && learn_q),
            .in             (in_q),
            .expected_out   (exp_q[i]),
            .out            (core_out[i]),
            .expected_in    (core_ei[i]),
            .weights        (weights[i]),
            .activation_max (activation_max[i]),
            .activation_min (activation_min[i])
        );
    end

    layer_expected_in_accumulator #(.N(N), .M(M), .L(L)) u_acc (
        .clock      (clock),
        .reset      (reset),
        .clear      (acc_clear),
        .step       (acc_step),
        .divide     (acc_div),
        .unavg      (core_ei),
        .last_group (last_group),
        .avg        (expected_in)
    );

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Directed bench for the sequenced learning layer: N=3/M=5/L=2 and the M=1/L=1 corner.
module tb_neuron_learn_layer_seq;
    import neuron_layer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic reset = 1'b1;

    logic                a_start = 1'b0, a_learn = 1'b0;
    zero2one_t [2:0]     a_in = '0;
    zero2one_t [4:0]     a_exp = '0;
    logic                a_ready, a_ov, a_eiv;
    zero2one_t [4:0]     a_out;
    zero2one_t [2:0]     a_ei;
    frac_t [4:0][2:0]    a_w;
    frac_t [4:0]         a_amax, a_amin;

    logic                b_start = 1'b0, b_learn = 1'b0;
    zero2one_t [2:0]     b_in = '0;
    zero2one_t [0:0]     b_exp = '0;
    logic                b_ready, b_ov, b_eiv;
    zero2one_t [0:0]     b_out;
    zero2one_t [2:0]     b_ei;
    frac_t [0:0][2:0]    b_w;
    frac_t [0:0]         b_amax, b_amin;

    neuron_learn_layer_seq #(.N(3), .M(5), .L(2), .NEURON_LAT(1)) dut_a (
        .clock(clk), .reset(reset), .start(a_start), .learn(a_learn),
        .in(a_in), .expected_out(a_exp), .ready(a_ready), .out(a_out),
        .out_valid(a_ov), .expected_in(a_ei), .expected_in_valid(a_eiv),
        .weights(a_w), .activation_max(a_amax), .activation_min(a_amin)
    );

    neuron_learn_layer_seq #(.N(3), .M(1), .L(1), .NEURON_LAT(1)) dut_b (
        .clock(clk), .reset(reset), .start(b_start), .learn(b_learn),
        .in(b_in), .expected_out(b_exp), .ready(b_ready), .out(b_out),
        .out_valid(b_ov), .expected_in(b_ei), .expected_in_valid(b_eiv),
        .weights(b_w), .activation_max(b_amax), .activation_min(b_amin)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request on dut_a (caller guarantees it is idle) and observes 20 cycles.
    task automatic run_a(input logic lrn, input zero2one_t [2:0] iv, input zero2one_t [4:0] ev,
                         output int vcyc, output int npulse, output logic eiv, output logic rdy1,
                         output zero2one_t [4:0] o, output zero2one_t [2:0] ei);
        a_in = iv; a_exp = ev; a_learn = lrn; a_start = 1'b1;
        vcyc = -1; npulse = 0; eiv = 1'b0; rdy1 = 1'b1; o = '0; ei = '0;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) rdy1 = a_ready;
            if (a_ov) begin
                npulse++;
                if (vcyc < 0) begin
                    vcyc = c; eiv = a_eiv; o = a_out; ei = a_ei;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", a_ready); end
        tests++; if (a_out !== 40'h0) begin fails++; $display("FAIL rst_out: got %h want 0", a_out); end
        tests++; if (a_ov !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", a_ov); end
        tests++; if (a_ei !== 24'h0) begin fails++; $display("FAIL rst_expected_in: got %h want 0", a_ei); end
        tests++; if (b_ready !== 1'b0) begin fails++; $display("FAIL rst_b_ready: got %b want 0", b_ready); end
        reset = 1'b0;
        #1;
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready: got %b want 1", a_ready); end
        tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL post_rst_b_ready: got %b want 1", b_ready); end
    endtask

    task automatic test_learn_avg();
        int vc, np; logic eiv, r1; zero2one_t [4:0] o; zero2one_t [2:0] ei;
        run_a(1'b1, {3{8'd255}}, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, vc, np, eiv, r1, o, ei);
        tests++; if (vc != 7) begin fails++; $display("FAIL learn_latency: got %0d want 7", vc); end
        tests++; if (np != 1) begin fails++; $display("FAIL learn_pulses: got %0d want 1", np); end
        tests++; if (eiv !== 1'b1) begin fails++; $display("FAIL learn_ei_valid: got %b want 1", eiv); end
        tests++; if (ei !== {8'd30, 8'd30, 8'd30}) begin fails++; $display("FAIL learn_avg: got %h want 1e1e1e", ei); end
        tests++; if (o !== {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}) begin fails++; $display("FAIL learn_out: got %h want 32281e140a", o); end
    endtask

    task automatic test_truncation();
        int vc, np; logic eiv, r1; zero2one_t [4:0] o; zero2one_t [2:0] ei;
        run_a(1'b1, {3{8'd255}}, {8'd49, 8'd40, 8'd30, 8'd20, 8'd10}, vc, np, eiv, r1, o, ei);
        tests++; if (vc != 7) begin fails++; $display("FAIL trunc_latency: got %0d want 7", vc); end
        tests++; if (ei !== {8'd29, 8'd29, 8'd29}) begin fails++; $display("FAIL trunc_avg: got %h want 1d1d1d", ei); end
    endtask

    task automatic test_inference();
        int vc, np; logic eiv, r1; zero2one_t [4:0] o; zero2one_t [2:0] ei;
        run_a(1'b0, {8'd200, 8'd50, 8'd100}, {8'd60, 8'd0, 8'd250, 8'd120, 8'd10}, vc, np, eiv, r1, o, ei);
        tests++; if (r1 !== 1'b0) begin fails++; $display("FAIL inf_ready_c1: got %b want 0", r1); end
        tests++; if (vc != 3) begin fails++; $display("FAIL inf_latency: got %0d want 3", vc); end
        tests++; if (np != 1) begin fails++; $display("FAIL inf_pulses: got %0d want 1", np); end
        tests++; if (eiv !== 1'b0) begin fails++; $display("FAIL inf_ei_valid: got %b want 0", eiv); end
        tests++; if (o !== {8'd60, 8'd0, 8'd200, 8'd120, 8'd10}) begin fails++; $display("FAIL inf_out: got %h want 3c00c8780a", o); end
        tests++; if (a_ei !== {8'd29, 8'd29, 8'd29}) begin fails++; $display("FAIL inf_ei_hold: got %h want 1d1d1d", a_ei); end
    endtask

    task automatic test_masking();
        int vc, np; logic eiv, r1; zero2one_t [4:0] o; zero2one_t [2:0] ei;
        run_a(1'b1, {3{8'd255}}, {8'd255, 8'd0, 8'd0, 8'd0, 8'd0}, vc, np, eiv, r1, o, ei);
        tests++; if (ei !== {8'd51, 8'd51, 8'd51}) begin fails++; $display("FAIL mask_avg: got %h want 333333", ei); end
    endtask

    task automatic test_back_to_back();
        int acc_q[$];
        int pv_q[$];
        int bad_gap = 0;
        int min_pv_gap = 1000;
        a_in = {3{8'd255}}; a_exp = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}; a_learn = 1'b1; a_start = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (a_ready) acc_q.push_back(t);
            if (a_ov) pv_q.push_back(t);
            tick();
        end
        a_start = 1'b0;
        repeat (12) tick();
        for (int i = 1; i < acc_q.size(); i++)
            if (acc_q[i] - acc_q[i-1] != 8) bad_gap++;
        for (int i = 1; i < pv_q.size(); i++)
            if (pv_q[i] - pv_q[i-1] < min_pv_gap) min_pv_gap = pv_q[i] - pv_q[i-1];
        tests++; if (acc_q.size() != 4) begin fails++; $display("FAIL b2b_accepts: got %0d want 4", acc_q.size()); end
        tests++; if (bad_gap != 0) begin fails++; $display("FAIL b2b_accept_gap: got %0d bad gaps want 0", bad_gap); end
        tests++; if (pv_q.size() != 3) begin fails++; $display("FAIL b2b_pulses: got %0d want 3", pv_q.size()); end
        tests++; if (min_pv_gap != 8) begin fails++; $display("FAIL b2b_pulse_gap: got %0d want 8", min_pv_gap); end
    endtask

    task automatic test_reset_in_acc();
        int stray = 0;
        int vc, np; logic eiv, r1; zero2one_t [4:0] o; zero2one_t [2:0] ei;
        a_in = {3{8'd255}}; a_exp = {8'd255, 8'd0, 8'd0, 8'd0, 8'd0}; a_learn = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL racc_ready_in_rst: got %b want 0", a_ready); end
        tests++; if (a_out !== 40'h0) begin fails++; $display("FAIL racc_out: got %h want 0", a_out); end
        tests++; if (a_ei !== 24'h0) begin fails++; $display("FAIL racc_expected_in: got %h want 0", a_ei); end
        reset = 1'b0;
        #1;
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL racc_idle: got %b want 1", a_ready); end
        for (int c = 0; c < 10; c++) begin
            if (a_ov) stray++;
            tick();
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL racc_no_valid: got %0d pulses want 0", stray); end
        run_a(1'b1, {3{8'd255}}, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, vc, np, eiv, r1, o, ei);
        tests++; if (vc != 7) begin fails++; $display("FAIL racc_retry_latency: got %0d want 7", vc); end
        tests++; if (ei !== {8'd30, 8'd30, 8'd30}) begin fails++; $display("FAIL racc_retry_avg: got %h want 1e1e1e", ei); end
    endtask

    task automatic test_single_neuron();
        int vc = -1;
        logic eiv = 1'b0;
        zero2one_t [2:0] ei = '0;
        zero2one_t [0:0] o = '0;
        b_in = {8'd9, 8'd8, 8'd7}; b_exp = 8'd255; b_learn = 1'b1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (b_ov && vc < 0) begin
                vc = c; eiv = b_eiv; ei = b_ei; o = b_out;
            end
            tick();
        end
        tests++; if (vc != 5) begin fails++; $display("FAIL m1_latency: got %0d want 5", vc); end
        tests++; if (eiv !== 1'b1) begin fails++; $display("FAIL m1_ei_valid: got %b want 1", eiv); end
        tests++; if (ei !== {8'd9, 8'd8, 8'd7}) begin fails++; $display("FAIL m1_avg: got %h want 090807", ei); end
        tests++; if (o !== 8'd9) begin fails++; $display("FAIL m1_out: got %h want 09", o); end
    endtask

    initial begin
        test_reset();
        test_learn_avg();
        test_truncation();
        test_inference();
        test_masking();
        test_back_to_back();
        test_reset_in_acc();
        test_single_neuron();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
